// File: rtl/booth8_pkg.sv
// booth8_pkg: shared types and sizing helpers for the radix-8 Booth multiplier
// Holds the FSM state enum, the digit multiple-select enum with its negate flag,
// and the functions that derive the multiplier register width QW and digit count N.
package booth8_pkg;
    typedef enum logic [1:0] {IDLE, PRE, CALC, DONE} state_t;
    typedef enum logic [2:0] {ZERO, M1, M2, M3, M4} sel_t;
    typedef struct packed {
        sel_t sel;
        logic neg;
    } digit_t;
    // QW is the smallest multiple of 3 that holds WIDTH bits plus a sign bit
    function automatic int qw_of(input int w);
        return 3 * ((w + 3) / 3);
    endfunction
    function automatic int n_of(input int w);
        return qw_of(w) / 3;
    endfunction
endpackage

// File: rtl/booth8_digit_enc.sv
// booth8_digit_enc: combinational radix-8 Booth digit encoder
// Ports: q3 - low three multiplier bits, qneg - previously retired bit,
//        dig - magnitude select (ZERO..M4) and negate flag for the digit in {-4..+4}.
module booth8_digit_enc import booth8_pkg::*; (
    input  logic [2:0] q3,
    input  logic       qneg,
    output digit_t     dig
);
    logic [2:0] t;
    logic [2:0] mag;
    // digit = -4*q2 + 2*q1 + q0 + qneg; with q2 set, inverting the low terms
    // yields the magnitude of the negative digit directly
    always_comb begin
        t = q3[2] ? ~{q3[1:0], qneg} : {q3[1:0], qneg};
        mag = {1'b0, t[2], 1'b0} + {2'b0, t[1]} + {2'b0, t[0]};
        dig.sel = sel_t'(mag);
        dig.neg = q3[2] & (mag != 3'd0);
    end
endmodule

// File: rtl/booth8_mult_param.sv
// booth8_mult_param: sequential radix-8 Booth multiplier, one digit per cycle
// Ports: clk, rst (sync active-high), start, is_signed, X (multiplier),
//        Y (multiplicand), busy, done (one-cycle pulse), product (2*WIDTH bits).
// Optional macro BOOTH8_OVF_EN adds output ovf, set when the product does not
// fit in WIDTH bits of the selected signedness; held with product.
module booth8_mult_param #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     X,
    input  logic [WIDTH-1:0]     Y,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
`ifdef BOOTH8_OVF_EN
    ,
    output logic                 ovf
`endif
);
    import booth8_pkg::*;
    localparam int QW = qw_of(WIDTH);
    localparam int N = n_of(WIDTH);
    localparam int AW = WIDTH + 3;
    localparam int PW = 2 * WIDTH;
    localparam logic [6:0] LAST = 7'(N - 1);
    state_t state, state_nx;
    logic [AW-1:0] a, m, m3, mult, sum;
    logic [QW-1:0] q;
    logic qneg;
    logic [6:0] cnt;
    logic [AW+QW-1:0] shifted;
    logic [PW-1:0] p;
    digit_t dig;
`ifdef BOOTH8_OVF_EN
    logic sgn;
`endif
    booth8_digit_enc u_enc (
        .q3   (q[2:0]),
        .qneg (qneg),
        .dig  (dig)
    );
    // single adder: negative digits use inverted multiple plus carry-in
    always_comb begin
        mult = dig.sel == M1 ? m :
               dig.sel == M2 ? m << 1 :
               dig.sel == M3 ? m3 :
               dig.sel == M4 ? m << 2 : '0;
        sum = a + (dig.neg ? ~mult : mult) + {{(AW-1){1'b0}}, dig.neg};
        shifted = $signed({sum, q}) >>> 3;
        p = PW'({a, q});
        state_nx = state == IDLE ? (start ? PRE : IDLE) :
                   state == PRE  ? CALC :
                   state == CALC ? (cnt == LAST ? DONE : CALC) : IDLE;
    end
    assign busy = state != IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a <= '0;
            q <= '0;
            qneg <= 1'b0;
            cnt <= '0;
            m <= '0;
            m3 <= '0;
            product <= '0;
            done <= 1'b0;
`ifdef BOOTH8_OVF_EN
            sgn <= 1'b0;
            ovf <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            done <= state == DONE;
            if (state == IDLE && start) begin
                q <= {{(QW-WIDTH){is_signed & X[WIDTH-1]}}, X};
                m <= {{3{is_signed & Y[WIDTH-1]}}, Y};
                a <= '0;
                qneg <= 1'b0;
                cnt <= '0;
`ifdef BOOTH8_OVF_EN
                sgn <= is_signed;
`endif
            end
            if (state == PRE) begin
                m3 <= m + (m << 1);
                cnt <= '0;
            end
            if (state == CALC) begin
                {a, q} <= shifted;
                qneg <= q[2];
                cnt <= cnt + 7'd1;
            end
            if (state == DONE) begin
                product <= p;
`ifdef BOOTH8_OVF_EN
                // signed fits when the top WIDTH+1 bits are all equal
                ovf <= sgn ? ~(&p[PW-1:WIDTH-1] | ~|p[PW-1:WIDTH-1]) : |p[PW-1:WIDTH];
`endif
            end
        end
    end
endmodule
